// File: rtl/mem_line_responder.sv
// Memory-side line responder: refill/write-back bursts with a fixed access latency.
// Optional MEM_BOUNDS_CHECK_EN adds an address-range check.
module mem_line_responder #(
  parameter int unsigned OFFSET_WIDTH   = 4,
  parameter int unsigned MEM_ADDR_WIDTH = 10,
  parameter int unsigned LATENCY        = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_write_i,
  input  logic [31:0] req_addr_i,
  input  logic        wdata_valid_i,
  output logic        wdata_ready_o,
  input  logic [31:0] wdata_i,
  output logic        rdata_valid_o,
  output logic [31:0] rdata_o,
  output logic        rdata_last_o,
  output logic        done_o,
  output logic        err_o
);

  localparam int unsigned LineSize = 2 ** (OFFSET_WIDTH - 2);
  localparam int unsigned BeatW    = OFFSET_WIDTH - 2;
  localparam int unsigned BaseW    = 32 - OFFSET_WIDTH;
  localparam int unsigned LatW     = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int unsigned LatLast  = (LATENCY > 0) ? LATENCY - 1 : 0;

  typedef enum logic [1:0] {StIdle, StWait, StRead, StWrite} state_e;

  state_e             state_q, state_d;
  logic [BeatW-1:0]   beat_q, beat_d;
  logic [LatW-1:0]    lat_q, lat_d;
  logic [BaseW-1:0]   base_q, base_d;
  logic               write_q, write_d;
  logic               accept;
  logic               last_beat;
  logic               discard;
  logic [BaseW+BeatW-1:0]    line_word;
  logic [MEM_ADDR_WIDTH-1:0] word_idx;
  logic [31:0]        mem [2**MEM_ADDR_WIDTH];
  logic               unused_addr_bits;

  assign unused_addr_bits = ^req_addr_i[OFFSET_WIDTH-1:0];

  assign accept    = req_valid_i & req_ready_o;
  assign last_beat = (beat_q == BeatW'(LineSize - 1));
  // Upper word-address bits alias onto the array.
  assign line_word = {base_q, beat_q};
  assign word_idx  = line_word[MEM_ADDR_WIDTH-1:0];

`ifdef MEM_BOUNDS_CHECK_EN
  logic oob_q, err_q, req_oob;

  assign req_oob = |req_addr_i[31:MEM_ADDR_WIDTH+2];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      oob_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      err_q <= accept & req_oob;
      if (accept) oob_q <= req_oob;
    end
  end

  assign discard = oob_q;
  assign err_o   = err_q & ~rst_i;
`else
  assign discard = 1'b0;
  assign err_o   = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      beat_q  <= '0;
      lat_q   <= '0;
      base_q  <= '0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      lat_q   <= lat_d;
      base_q  <= base_d;
      write_q <= write_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    beat_d        = beat_q;
    lat_d         = lat_q;
    base_d        = base_q;
    write_d       = write_q;
    req_ready_o   = 1'b0;
    wdata_ready_o = 1'b0;
    rdata_valid_o = 1'b0;
    rdata_last_o  = 1'b0;
    done_o        = 1'b0;
    unique case (state_q)
      StIdle: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          base_d  = req_addr_i[31:OFFSET_WIDTH];
          write_d = req_write_i;
          beat_d  = '0;
          lat_d   = '0;
          state_d = (LATENCY > 0) ? StWait : (req_write_i ? StWrite : StRead);
        end
      end
      StWait: begin
        lat_d = lat_q + 1'b1;
        if (lat_q == LatW'(LatLast)) begin
          lat_d   = '0;
          state_d = write_q ? StWrite : StRead;
        end
      end
      StRead: begin
        rdata_valid_o = 1'b1;
        beat_d        = beat_q + 1'b1;
        if (last_beat) begin
          rdata_last_o = 1'b1;
          done_o       = 1'b1;
          state_d      = StIdle;
        end
      end
      StWrite: begin
        wdata_ready_o = 1'b1;
        if (wdata_valid_i) begin
          beat_d = beat_q + 1'b1;
          if (last_beat) begin
            done_o  = 1'b1;
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    // Reset cycle forces every output low and blocks request accept.
    if (rst_i) begin
      req_ready_o   = 1'b0;
      wdata_ready_o = 1'b0;
      rdata_valid_o = 1'b0;
      rdata_last_o  = 1'b0;
      done_o        = 1'b0;
    end
  end

  assign rdata_o = (rdata_valid_o & ~discard) ? mem[word_idx] : '0;

  always_ff @(posedge clk_i) begin
    if (wdata_ready_o & wdata_valid_i & ~discard) mem[word_idx] <= wdata_i;
  end

endmodule

// File: tb/tb_mem_line_responder.sv
// Bench for mem_line_responder: a planned cycle timeline drives stimulus and a burst-level model
// fills per-cycle expectations; one negedge process compares every output every cycle.
module tb_mem_line_responder;
  localparam int OW = 4, LINE = 4, LAT = 2, MAW = 10, NCYC = 400;
`ifdef MEM_BOUNDS_CHECK_EN
  localparam bit BoundsEn = 1'b1;
`else
  localparam bit BoundsEn = 1'b0;
`endif

  logic clk = 1'b0, rst, req_valid, req_ready, req_write, wdata_valid, wdata_ready;
  logic rdata_valid, rdata_last, done, err;
  logic [31:0] req_addr, wdata, rdata;

  mem_line_responder #(.OFFSET_WIDTH(OW), .MEM_ADDR_WIDTH(MAW), .LATENCY(LAT)) dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_write_i(req_write), .req_addr_i(req_addr), .wdata_valid_i(wdata_valid),
    .wdata_ready_o(wdata_ready), .wdata_i(wdata), .rdata_valid_o(rdata_valid),
    .rdata_o(rdata), .rdata_last_o(rdata_last), .done_o(done), .err_o(err)
  );

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Planned stimulus and expected outputs, indexed by cycle.
  logic d_rst [NCYC], d_rv [NCYC], d_rw [NCYC], d_wv [NCYC];
  logic [31:0] d_ra [NCYC], d_wd [NCYC], e_rd [NCYC];
  logic e_rdy [NCYC], e_wrdy [NCYC], e_rv [NCYC], e_last [NCYC], e_done [NCYC], e_err [NCYC];
  logic [31:0] mmem [1024];
  int last_c = NCYC - 2;

  typedef struct {int c; int sel; logic [31:0] v;} lit_t;
  lit_t lits[$];

  int checks = 0, errors = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endfunction

  function automatic bit is_oob(logic [31:0] addr);
    return BoundsEn && ((addr >> (MAW + 2)) != 0);
  endfunction

  function automatic int sched_read(int t, logic [31:0] addr);
    int wb = int'(addr >> 2) & ~(LINE - 1);
    bit oob = is_oob(addr);
    d_rv[t] = 1'b1; d_rw[t] = 1'b0; d_ra[t] = addr;
    e_err[t+1] = oob;
    for (int c = t + 1; c <= t + LAT + LINE; c++) e_rdy[c] = 1'b0;
    for (int k = 0; k < LINE; k++) begin
      e_rv[t+1+LAT+k]   = 1'b1;
      e_rd[t+1+LAT+k]   = oob ? 32'h0 : mmem[(wb + k) % 1024];
      e_last[t+1+LAT+k] = (k == LINE - 1);
      e_done[t+1+LAT+k] = (k == LINE - 1);
    end
    return t + LAT + LINE;
  endfunction

  function automatic int sched_write(int t, logic [31:0] addr, logic [7:0] pat, int plen,
                                     logic [31:0] dbase);
    int wb = int'(addr >> 2) & ~(LINE - 1);
    bit oob = is_oob(addr);
    int k = 0, e = t + LAT + plen;
    d_rv[t] = 1'b1; d_rw[t] = 1'b1; d_ra[t] = addr;
    e_err[t+1] = oob;
    for (int p = 0; p < plen; p++) begin
      int c = t + 1 + LAT + p;
      e_wrdy[c] = 1'b1;
      d_wv[c]   = pat[p];
      d_wd[c]   = pat[p] ? dbase + k : 32'hBAD0;
      if (pat[p]) begin
        if (!oob) mmem[(wb + k) % 1024] = dbase + k;
        k++;
        if (k == LINE) begin
          e_done[c] = 1'b1;
          e = c;
          break;
        end
      end
    end
    for (int c = t + 1; c <= e; c++) e_rdy[c] = 1'b0;
    return e;
  endfunction

  // Reset at cycle r aborts whatever was planned up to cycle e.
  function automatic void apply_reset(int r, int e);
    d_rst[r] = 1'b1;
    for (int c = r; c <= e; c++) begin
      e_rv[c] = 0; e_rd[c] = 0; e_last[c] = 0; e_done[c] = 0; e_err[c] = 0; e_wrdy[c] = 0;
      e_rdy[c] = (c > r);
    end
  endfunction

  function automatic void add_lit(int c, int sel, logic [31:0] v);
    lit_t l;
    l.c = c; l.sel = sel; l.v = v;
    lits.push_back(l);
  endfunction

  function automatic logic [31:0] sig(int sel);
    case (sel)
      0: return rdata;
      1: return {31'b0, rdata_valid};
      2: return {31'b0, rdata_last};
      3: return {31'b0, done};
      4: return {31'b0, req_ready};
      default: return {31'b0, err};
    endcase
  endfunction

  function automatic string sig_name(int sel);
    case (sel)
      0: return "lit_rdata";
      1: return "lit_rdata_valid";
      2: return "lit_rdata_last";
      3: return "lit_done";
      4: return "lit_req_ready";
      default: return "lit_err";
    endcase
  endfunction

  task automatic drive(int c);
    rst = d_rst[c]; req_valid = d_rv[c]; req_write = d_rw[c]; req_addr = d_ra[c];
    wdata_valid = d_wv[c]; wdata = d_wd[c];
  endtask

  always @(negedge clk) begin
    if (cyc >= 1 && cyc <= last_c) begin
      chk("req_ready", {31'b0, req_ready}, {31'b0, e_rdy[cyc]});
      chk("wdata_ready", {31'b0, wdata_ready}, {31'b0, e_wrdy[cyc]});
      chk("rdata_valid", {31'b0, rdata_valid}, {31'b0, e_rv[cyc]});
      chk("rdata", rdata, e_rd[cyc]);
      chk("rdata_last", {31'b0, rdata_last}, {31'b0, e_last[cyc]});
      chk("done", {31'b0, done}, {31'b0, e_done[cyc]});
      chk("err", {31'b0, err}, {31'b0, e_err[cyc]});
      foreach (lits[i]) if (lits[i].c == cyc) chk(sig_name(lits[i].sel), sig(lits[i].sel), lits[i].v);
    end
  end

  initial begin
    int t, e, tr1, th, tw, tb, t0, t1, tr;
    for (int c = 0; c < NCYC; c++) begin
      d_rst[c] = 0; d_rv[c] = 0; d_rw[c] = 0; d_wv[c] = 0; d_ra[c] = 0; d_wd[c] = 0;
      e_rdy[c] = 1; e_wrdy[c] = 0; e_rv[c] = 0; e_rd[c] = 0; e_last[c] = 0; e_done[c] = 0;
      e_err[c] = 0;
    end
    for (int i = 0; i < 1024; i++) mmem[i] = 32'h0;
    for (int c = 0; c < 3; c++) begin
      d_rst[c] = 1; e_rdy[c] = 0;
    end
    add_lit(2, 4, 32'h0);
    add_lit(3, 4, 32'h1);

    // Write line 0x100, with stray write beats during the latency window.
    t = 3;
    e = sched_write(t, 32'h100, 8'h0F, 4, 32'hA0);
    d_wv[t+1] = 1; d_wd[t+1] = 32'hDEAD; d_wv[t+2] = 1; d_wd[t+2] = 32'hDEAD;
    t = e + 1;
    // Read back immediately after done, with a stray write beat in IDLE.
    tr1 = t;
    e = sched_read(t, 32'h100);
    d_wv[t] = 1; d_wd[t] = 32'hBEEF;
    add_lit(tr1 + 2, 1, 32'h0);
    add_lit(tr1 + 3, 0, 32'hA0);
    add_lit(tr1 + 4, 0, 32'hA1);
    add_lit(tr1 + 5, 0, 32'hA2);
    add_lit(tr1 + 6, 0, 32'hA3);
    add_lit(tr1 + 5, 2, 32'h0);
    add_lit(tr1 + 6, 2, 32'h1);
    add_lit(tr1 + 6, 3, 32'h1);
    t = e + 1;
    // Unaligned read of the same line with req_valid held through the burst.
    th = t;
    e = sched_read(t, 32'h10C);
    for (int c = th; c <= e; c++) begin
      d_rv[c] = 1; d_ra[c] = 32'h10C;
    end
    add_lit(th + 1, 4, 32'h0);
    add_lit(th + 3, 0, 32'hA0);
    add_lit(th + 6, 0, 32'hA3);
    t = e + 1;
    // Held request is a write accepted in the first IDLE cycle; data gaps 1,0,1,1,1.
    tw = t;
    e = sched_write(t, 32'h200, 8'h1D, 5, 32'hB0);
    add_lit(tw, 4, 32'h1);
    add_lit(tw + 6, 3, 32'h0);
    add_lit(tw + 7, 3, 32'h1);
    t = e + 1;
    e = sched_read(t, 32'h200);
    add_lit(t + 3, 0, 32'hB0);
    add_lit(t + 6, 0, 32'hB3);
    t = e + 1;
    // Range/aliasing: line 0x0000 then 0x1000.
    e = sched_write(t, 32'h0, 8'h0F, 4, 32'h11);
    t = e + 1;
    tb = t;
    e = sched_write(t, 32'h1000, 8'h0F, 4, 32'h55);
    add_lit(tb + 1, 5, {31'b0, BoundsEn});
    t = e + 1;
    t0 = t;
    e = sched_read(t, 32'h0);
    add_lit(t0 + 3, 0, BoundsEn ? 32'h11 : 32'h55);
    t = e + 1;
    t1 = t;
    e = sched_read(t, 32'h1000);
    add_lit(t1 + 3, 0, BoundsEn ? 32'h0 : 32'h55);
    t = e + 1;
    // Reset during read beat 2.
    tr = t;
    e = sched_read(t, 32'h100);
    apply_reset(tr + 5, tr + 6);
    add_lit(tr + 4, 1, 32'h1);
    add_lit(tr + 6, 1, 32'h0);
    add_lit(tr + 6, 4, 32'h1);
    t = tr + 6;
    e = sched_read(t, 32'h100);
    add_lit(t + 3, 0, 32'hA0);
    last_c = e + 3;

    drive(0);
    for (int c = 1; c <= last_c; c++) begin
      @(posedge clk);
      #1;
      drive(c);
    end
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
